// File: rtl/shift_register_ctrl.sv
// shift_register_ctrl: valid/ready sequencer for a fixed-latency serial shift chain.
// A parallel word is accepted, driven LSB-first on sr_in, and the bits returning
// on sr_out are reassembled into out_data.
// Optional feature macro: SR_CTRL_LOOPBACK_CHECK_EN adds an err output that
// flags a returned word differing from the word that was sent.
module shift_register_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sr_in,
  input  logic             sr_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef SR_CTRL_LOOPBACK_CHECK_EN
  output logic             err,
`endif
  output logic             busy
);

  localparam int N  = WIDTH + DEPTH;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_CYC = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
`ifdef SR_CTRL_LOOPBACK_CHECK_EN
  logic             err_q, err_d;
`endif

  // Next-state, bit counter, word latch and capture of returning serial bits.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    word_d     = word_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d  = in_data;
          cyc_d   = {CW{1'b0}};
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Bit i of the result returns DEPTH cycles after it was sent; comparing
        // against each legal index keeps every write inside out_data.
        for (int i = 0; i < WIDTH; i++) begin
          if (cyc_q == CW'(DEPTH + i)) begin
            out_data_d[i] = sr_out;
          end else begin
            out_data_d[i] = out_data_q[i];
          end
        end
        cyc_d = cyc_q + {{(CW-1){1'b0}}, 1'b1};
        if (cyc_q == LAST_CYC) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SR_CTRL_LOOPBACK_CHECK_EN
  // Loopback compare: evaluated on the edge entering DONE, cleared on the out handshake.
  always_comb begin
    err_d = err_q;
    if ((state_q == SHIFT) && (cyc_q == LAST_CYC)) begin
      err_d = (out_data_d != word_q);
    end else if ((state_q == DONE) && out_ready) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end
`endif

  // Serial bit to the chain: word bits while cyc < WIDTH, zeros while flushing.
  always_comb begin
    sr_in = 1'b0;
    if (state_q == SHIFT) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (cyc_q == CW'(i)) begin
          sr_in = word_q[i];
        end else begin
          sr_in = sr_in;
        end
      end
    end else begin
      sr_in = 1'b0;
    end
  end

  // Handshake and status flags decoded from the registered state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_data  = out_data_q;
  end

`ifdef SR_CTRL_LOOPBACK_CHECK_EN
  assign err = err_q;
`endif

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cyc_q      <= {CW{1'b0}};
      word_q     <= {WIDTH{1'b0}};
      out_data_q <= {WIDTH{1'b0}};
`ifdef SR_CTRL_LOOPBACK_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      word_q     <= word_d;
      out_data_q <= out_data_d;
`ifdef SR_CTRL_LOOPBACK_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Self-checking bench for shift_register_ctrl with an ideal 5-flop chain model.
module tb_shift_register_ctrl;

  localparam int W = 8;
  localparam int D = 5;
  localparam int N = W + D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = 8'h00;
  logic         sr_in;
  logic         sr_out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         busy;
`ifdef SR_CTRL_LOOPBACK_CHECK_EN
  logic         err;
`endif

  logic         flip = 1'b0;
  logic [D-1:0] chain;

  int checks = 0;
  int failures = 0;

  int           cycle_cnt = 0;
  int           acc_cyc[$];
  logic [W-1:0] outq[$];

  shift_register_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sr_in     (sr_in),
    .sr_out    (sr_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef SR_CTRL_LOOPBACK_CHECK_EN
    .err       (err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Ideal chain: a bit sampled from sr_in on edge t is sampled back by the DUT on edge t+5.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[D-2:0], sr_in ^ flip};
  end
  assign sr_out = chain[D-1];

  // Monitor of accept edges and delivered words.
  always @(posedge clk) begin
    cycle_cnt <= cycle_cnt + 1;
    if (rst_n && in_valid && in_ready) acc_cyc.push_back(cycle_cnt);
    if (rst_n && out_valid && out_ready) outq.push_back(out_data);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete transfer; flip_idx >= 0 corrupts that bit inside the chain.
  task automatic run_word(input logic [W-1:0] d, input logic [W-1:0] exp_d,
                          input int hold, input int flip_idx);
    logic [N-1:0] ser;
    bit           bad;
    int           w;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b0;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
    ser = '0;
    bad = 1'b0;
    for (int k = 0; k < N; k++) begin
      ser[k] = sr_in;
      if (out_valid || !busy || in_ready) bad = 1'b1;
      flip = (k == flip_idx);
      @(negedge clk);
    end
    flip = 1'b0;
    check("serial_bits", {19'd0, ser}, {19'd0, 5'd0, d});
    check("shift_flags", {31'd0, bad}, 32'd0);
    check("valid_at_N", {31'd0, out_valid}, 32'd1);
    check("out_data", {24'd0, out_data}, {24'd0, exp_d});
`ifdef SR_CTRL_LOOPBACK_CHECK_EN
    check("err_done", {31'd0, err}, {31'd0, (exp_d != d)});
`endif
    if (hold > 0) begin
      bad = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hEE;
      for (int h = 0; h < hold; h++) begin
        if (!out_valid || out_data !== exp_d || in_ready || !busy) bad = 1'b1;
        @(negedge clk);
      end
      in_valid = 1'b0;
      in_data  = 8'h00;
      check("hold_stable", {31'd0, bad}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", {31'd0, out_valid}, 32'd0);
    check("post_idle", {30'd0, busy, in_ready}, 32'd1);
    check("post_retain", {24'd0, out_data}, {24'd0, exp_d});
`ifdef SR_CTRL_LOOPBACK_CHECK_EN
    check("err_clear", {31'd0, err}, 32'd0);
`endif
  endtask

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] dexp;
    int           hold;
    int           flip_idx;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int w;
    int base;
    bit seen;
    vecs[0] = '{8'hA5, 8'hA5, 0, -1};
    vecs[1] = '{8'hA5, 8'hA5, 10, -1};
    vecs[2] = '{8'h01, 8'h01, 0, -1};
    vecs[3] = '{8'h80, 8'h80, 0, -1};
    vecs[4] = '{8'h5A, 8'h52, 0, 3};
    vecs[5] = '{8'h5A, 8'h5A, 0, -1};

    // Reset state.
    #3 rst_n = 1'b0;
    #1;
    check("rst_async", {28'd0, out_valid, sr_in, busy, 1'b0}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {30'd0, in_ready, busy}, 32'd2);
    check("rst_valid", {31'd0, out_valid}, 32'd0);

    // Table-driven transfers.
    for (int i = 0; i < 6; i++) begin
      run_word(vecs[i].din, vecs[i].dexp, vecs[i].hold, vecs[i].flip_idx);
    end

    // Reset in the middle of shifting 8'h3C.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags", {29'd0, busy, out_valid, sr_in}, 32'd0);
    check("mid_rst_data", {24'd0, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid || busy) seen = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("mid_no_valid", {31'd0, seen}, 32'd0);
    run_word(8'h81, 8'h81, 0, -1);

    // Back-to-back 8'h00 then 8'hFF with in_valid and out_ready held high.
    acc_cyc.delete();
    outq.delete();
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 8'h00;
    out_ready = 1'b1;
    w = 0;
    while (acc_cyc.size() < 1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    in_data = 8'hFF;
    while (acc_cyc.size() < 2 && w < 100) begin
      @(negedge clk);
      w++;
    end
    in_valid = 1'b0;
    while (outq.size() < 2 && w < 150) begin
      @(negedge clk);
      w++;
    end
    out_ready = 1'b0;
    check("b2b_accepts", acc_cyc.size(), 32'd2);
    check("b2b_outs", outq.size(), 32'd2);
    if (acc_cyc.size() == 2) begin
      base = acc_cyc[1] - acc_cyc[0];
      check("b2b_spacing", base, N + 2);
    end else begin
      check("b2b_spacing", 32'hFFFF_FFFF, N + 2);
    end
    if (outq.size() == 2) begin
      check("b2b_first", {24'd0, outq[0]}, 32'h00);
      check("b2b_second", {24'd0, outq[1]}, 32'hFF);
    end else begin
      check("b2b_data", outq.size(), 32'd2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
